// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU issue arbiter
// Contents:
//   state_t     : arbiter FSM states (IDLE / EXEC / WAIT_CDB)
//   op_class_t  : latched class of the issued instruction
//   ALUOP_MUL   : ALUop encoding of a multiply
//   op_classify : maps (ALUop, branch flag) to an op class
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_CDB = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OTHER  = 2'd0,
    OP_MUL    = 2'd1,
    OP_BRANCH = 2'd2
  } op_class_t;

  localparam logic [3:0] ALUOP_MUL = 4'b0010;

  // Branches never produce a CDB result, so the branch flag takes priority
  // over the ALUop encoding.
  function automatic op_class_t op_classify(input logic [3:0] aluop, input logic branch);
    if (branch)
      return OP_BRANCH;
    else if (aluop == ALUOP_MUL)
      return OP_MUL;
    else
      return OP_OTHER;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational one-hot pick among N requesters
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no ptr port); otherwise round-robin starting at ptr.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  round-robin start index (round-robin build only)
//   grant out N   one-hot winner (zero when no request)
//   idx   out IW  winner index
//   any   out 1   at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end
`else
  logic found;
  int   pos;

  // Visit indices ptr, ptr+1, ... (mod N); the first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = IW'(pos);
        found      = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_issue_arb.sv
// rtl/alu_issue_arb.sv - issue arbiter for the shared SIMD ALU
// Build option: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   Req_OC_Arb          per-OC request, held until granted
//   ALUop_OC_Arb        per-OC ALUop, OC i at [4i+3:4i]
//   Branch_OC_Arb       per-OC branch flag
//   Grant_Arb_OC        one-hot accept pulse (combinational)
//   Sel_Arb_Mux         registered index of the OC driving the ALU
//   Valid_Arb_ALU       ALU operands valid
//   CDB_Req_Arb_CDB     result ready for the CDB
//   CDB_Grant_CDB_Arb   CDB accepts the result this cycle
//   Busy_Arb            arbiter not idle
module alu_issue_arb
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         Req_OC_Arb,
  input  logic [NUM_REQ*4-1:0]       ALUop_OC_Arb,
  input  logic [NUM_REQ-1:0]         Branch_OC_Arb,
  output logic [NUM_REQ-1:0]         Grant_Arb_OC,
  output logic [$clog2(NUM_REQ)-1:0] Sel_Arb_Mux,
  output logic                       Valid_Arb_ALU,
  output logic                       CDB_Req_Arb_CDB,
  input  logic                       CDB_Grant_CDB_Arb,
  output logic                       Busy_Arb
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);

  state_t              state, state_nxt;
  op_class_t           cls, win_cls;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       sel, pick_idx;
  logic [NUM_REQ-1:0]  req_eff, pick_grant;
  logic                pick_any, cnt_zero, retire, grant_en, grant_fire, cdb_req;
  logic [3:0]          win_op;

  // Requests are ignored while reset is held so no grant pulse escapes.
  assign req_eff = Req_OC_Arb & {NUM_REQ{rst_n}};

`ifdef ALU_ARB_FIXED_PRIO_EN
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_eff),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );
`else
  logic [IW-1:0] ptr;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_eff),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );
`endif

  assign cnt_zero = (cnt == '0);
  assign win_op   = ALUop_OC_Arb[4*int'(pick_idx) +: 4];
  assign win_cls  = op_classify(win_op, Branch_OC_Arb[pick_idx]);

  always_comb begin
    state_nxt = state;
    cdb_req   = 1'b0;
    retire    = 1'b0;
    case (state)
      EXEC: begin
        if (cnt_zero) begin
          if (cls == OP_BRANCH) begin
            retire = 1'b1;
          end else begin
            cdb_req = 1'b1;
            if (CDB_Grant_CDB_Arb) retire = 1'b1;
            else                   state_nxt = WAIT_CDB;
          end
        end
      end
      WAIT_CDB: begin
        cdb_req = 1'b1;
        if (CDB_Grant_CDB_Arb) retire = 1'b1;
      end
      default: ;
    endcase
    // A retiring instruction frees the ALU in the same cycle, which is what
    // allows one issue per cycle for back-to-back single-cycle ops.
    grant_en   = (state == IDLE) || retire;
    grant_fire = grant_en && pick_any;
    if (grant_fire)  state_nxt = EXEC;
    else if (retire) state_nxt = IDLE;
  end

  assign Grant_Arb_OC    = grant_fire ? pick_grant : '0;
  assign Sel_Arb_Mux     = sel;
  assign Valid_Arb_ALU   = (state != IDLE);
  assign Busy_Arb        = (state != IDLE);
  assign CDB_Req_Arb_CDB = cdb_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      cls   <= OP_OTHER;
      cnt   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        sel <= pick_idx;
        cls <= win_cls;
        cnt <= (win_cls == OP_MUL) ? MUL_LOAD : '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_arb.sv
// tb/tb_alu_issue_arb.sv - self-checking bench for alu_issue_arb
module tb_alu_issue_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] aluop = '0;
  logic [3:0]  br = '0;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        valid, cdb_req, cdb_grant = 1'b0, busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_arb #(.NUM_REQ(4), .MUL_LAT(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Req_OC_Arb        (req),
    .ALUop_OC_Arb      (aluop),
    .Branch_OC_Arb     (br),
    .Grant_Arb_OC      (grant),
    .Sel_Arb_Mux       (sel),
    .Valid_Arb_ALU     (valid),
    .CDB_Req_Arb_CDB   (cdb_req),
    .CDB_Grant_CDB_Arb (cdb_grant),
    .Busy_Arb          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] op;
    logic [3:0]  br;
    logic        cg;
    logic [3:0]  eg;
    logic [1:0]  es;
    logic        ev;
    logic        ec;
    logic        eb;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic ec, input logic eb);
    n_cmp++;
    if (grant !== eg || sel !== es || valid !== ev || cdb_req !== ec || busy !== eb) begin
      n_bad++;
      $display("FAIL %s: got grant=%b sel=%0d valid=%b cdb_req=%b busy=%b, want grant=%b sel=%0d valid=%b cdb_req=%b busy=%b",
               name, grant, sel, valid, cdb_req, busy, eg, es, ev, ec, eb);
    end
  endtask

  initial begin
    // Cycle-by-cycle trace; inputs applied at negedge, outputs checked 1ns later.
    //           req    op       br    cg     grant  sel   v     c     busy
    tbl[0]  = '{4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0}; // idle after reset
    tbl[1]  = '{4'h1, 16'h0000, 4'h0, 1'b1, 4'h1, 2'd0, 1'b0, 1'b0, 1'b0}; // single add grant
    tbl[2]  = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1}; // exec + CDB retire
    tbl[3]  = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0}; // back to idle
    tbl[4]  = '{4'hF, 16'h0000, 4'h0, 1'b1, 4'h2, 2'd0, 1'b0, 1'b0, 1'b0}; // RR from ptr=1
    tbl[5]  = '{4'hF, 16'h0000, 4'h0, 1'b1, 4'h4, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{4'hF, 16'h0000, 4'h0, 1'b1, 4'h8, 2'd2, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{4'hF, 16'h0000, 4'h0, 1'b1, 4'h1, 2'd3, 1'b1, 1'b1, 1'b1}; // wrap
    tbl[8]  = '{4'hF, 16'h0000, 4'h0, 1'b1, 4'h2, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'h4, 16'h0200, 4'h0, 1'b1, 4'h4, 2'd1, 1'b0, 1'b0, 1'b0}; // OC2 multiply
    tbl[12] = '{4'h1, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd2, 1'b1, 1'b0, 1'b1}; // held, CDB grant ignored
    tbl[13] = '{4'h1, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd2, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{4'h1, 16'h0000, 4'h0, 1'b1, 4'h1, 2'd2, 1'b1, 1'b1, 1'b1}; // mul retire + new grant
    tbl[15] = '{4'h2, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1}; // CDB stalls
    tbl[16] = '{4'h2, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1}; // WAIT_CDB
    tbl[17] = '{4'h2, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{4'h2, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[19] = '{4'h2, 16'h0000, 4'h2, 1'b1, 4'h2, 2'd0, 1'b1, 1'b1, 1'b1}; // retire + branch grant
    tbl[20] = '{4'h0, 16'h0000, 4'h0, 1'b1, 4'h0, 2'd1, 1'b1, 1'b0, 1'b1}; // branch: no CDB req
    tbl[21] = '{4'h0, 16'h0000, 4'h0, 1'b0, 4'h0, 2'd1, 1'b0, 1'b0, 1'b0};

    // Reset held with all requests high: nothing may be granted.
    req = 4'hF;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'h0;
    rst_n = 1'b1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    req = 4'hF;
    cdb_grant = 1'b1;
    #1 check("fixed_first", 4'h1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1 check($sformatf("fixed_%0d", i), 4'h1, 2'd0, 1'b1, 1'b1, 1'b1);
    end
`else
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      req       = tbl[i].req;
      aluop     = tbl[i].op;
      br        = tbl[i].br;
      cdb_grant = tbl[i].cg;
      #1 check($sformatf("vec_%0d", i), tbl[i].eg, tbl[i].es, tbl[i].ev, tbl[i].ec, tbl[i].eb);
    end

    // Asynchronous reset while stalled in WAIT_CDB (ptr=2 here, so OC0 wins).
    @(negedge clk);
    req = 4'h1; aluop = '0; br = '0; cdb_grant = 1'b0;
    #1 check("rst_seq_grant", 4'h1, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    req = 4'h0;
    #1 check("rst_seq_exec", 4'h0, 2'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #1 check("rst_seq_wait", 4'h0, 2'd0, 1'b1, 1'b1, 1'b1);
    req = 4'hF;
    #1 rst_n = 1'b0;
    #1 check("rst_async_drop", 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cdb_grant = 1'b1;
    #1 check("post_rst_ptr0", 4'h1, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 check("post_rst_next", 4'h2, 2'd0, 1'b1, 1'b1, 1'b1);
`endif

    @(negedge clk);
    req = 4'h0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_arb.md
# alu_issue_arb

Issue controller for the shared SIMD ALU. Arbitrates among `NUM_REQ` operand-collector (OC) units that hold ready ALU/branch instructions, steers the winner's payload onto the ALU through an external mux select, holds multiplies for a multi-cycle window, and handshakes with the CDB arbiter before retiring non-branch results. It sits between the OC units and `ALU`, and owns `Valid_OC_ALU`.

## Interface
- `NUM_REQ`, 4: number of OC units competing for the ALU (≥2).
- `MUL_LAT`, 3: cycles the ALU is held for a multiply (ALUop `4'b0010`), ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `Req_OC_Arb`  in  NUM_REQ  per-OC request; held until granted.
- `ALUop_OC_Arb`  in  NUM_REQ*4  per-OC ALUop, flattened, OC i at [4i+3:4i].
- `Branch_OC_Arb`  in  NUM_REQ  per-OC BEQ|BLT flag.
- `Grant_Arb_OC`  out  NUM_REQ  one-hot accept pulse; OC i drops or replaces its request next cycle.
- `Sel_Arb_Mux`  out  $clog2(NUM_REQ)  registered index of the OC driving the ALU inputs.
- `Valid_Arb_ALU`  out  1  drives `Valid_OC_ALU`.
- `CDB_Req_Arb_CDB`  out  1  result ready for CDB.
- `CDB_Grant_CDB_Arb`  in  1  CDB accepts the result this cycle.
- `Busy_Arb`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, EXEC, WAIT_CDB.
- Grant enabled when state=IDLE, or in the retire cycle of EXEC/WAIT_CDB. If enabled and any `Req_OC_Arb`: exactly one `Grant_Arb_OC` bit high (combinational). `Sel`, latched op class (mul/branch/other), and counter load on that edge; next state EXEC.
- Arbitration: round-robin. Search starts at pointer `ptr`; on grant to i, `ptr` ← (i+1) mod NUM_REQ.
- EXEC: `Valid_Arb_ALU`=1. Counter loads MUL_LAT−1 for a multiply, 0 otherwise, and decrements each cycle while nonzero.
  - Counter=0, branch: retire (ALU clears the Scb entry; Valid held exactly 1 cycle).
  - Counter=0, non-branch: `CDB_Req_Arb_CDB`=1; if `CDB_Grant_CDB_Arb`, retire; else go to WAIT_CDB.
- WAIT_CDB: `Valid_Arb_ALU`=1, `CDB_Req_Arb_CDB`=1, `Sel` frozen. Retire on `CDB_Grant_CDB_Arb`.
- Retire: if a new grant is made in the same cycle, stay in/enter EXEC; otherwise go to IDLE.
- `CDB_Grant_CDB_Arb` is ignored when `CDB_Req_Arb_CDB`=0.

## Timing
- Reset: state IDLE, `ptr`=0, `Sel`=0, counter=0. All outputs 0 (`Grant` is 0 since state IDLE needs Req, and Req is forced ignored during reset).
- Grant at cycle t → `Valid_Arb_ALU` from t+1.
- Non-mul, non-branch with immediate CDB grant: retires at t+1; back-to-back throughput is 1 instruction/cycle.
- Multiply: Valid t+1..t+MUL_LAT; CDB_Req at t+MUL_LAT.
- Branch: Valid only at t+1; no CDB_Req.
- Reset asserted mid-EXEC/WAIT_CDB: immediate IDLE, Valid/CDB_Req drop asynchronously; the in-flight instruction is discarded.
- All requests simultaneous: RR order from `ptr`; no requester waits more than NUM_REQ grants.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins; `ptr` logic removed.
- Undefined: round-robin as above.

## Structure
- Package `alu_arb_pkg`: state enum (IDLE/EXEC/WAIT_CDB), `ALUOP_MUL`=4'b0010, op-class encoding.
- Sub-module `rr_pick`: combinational pick of one-hot grant + index from request vector and `ptr` (fixed-priority variant under the macro).

## Test plan
- Reset, then Req=4'b0001, ALUop=0000, CDB_Grant=1 → Grant=0001 at t, Sel=0 and Valid=1 and CDB_Req=1 at t+1, IDLE at t+2.
- Req=4'b1111 held, all add, CDB_Grant=1 → grants 0,1,2,3,0 on consecutive cycles; Valid continuously high.
- OC2 multiply, MUL_LAT=3 → Valid t+1..t+3, CDB_Req only at t+3, no grant before t+3.
- Add with CDB_Grant=0 for 4 cycles, then 1 → WAIT_CDB, Sel stable, no grant until the retire cycle.
- Branch on OC1 → Valid one cycle, CDB_Req never high; rst_n low during WAIT_CDB → outputs 0 immediately.
- With `ALU_ARB_FIXED_PRIO_EN`, Req=1111 held → OC0 always granted.
